// File: rtl/alu_bitserial_seq_pkg.sv
// Shared op codes and sequencer state encoding for the bit-serial ALU.
package alu_bitserial_seq_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_e;

endpackage

// File: rtl/alu_bitserial_seq_if.sv
// Request/result bundle between the operand/writeback logic and the sequencer.
interface alu_bitserial_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, cout, ovf, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, cout, ovf, zero
  );
endinterface

// File: rtl/alu_bitserial_seq_alu1b.sv
// One-bit ALU slice: AND/OR on raw b, full adder on b optionally inverted.
// set is the adder sum bit, used by the MSB slice for SLT.
module alu1b (
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic       less,
  input  logic [2:0] op,
  output logic       r,
  output logic       co,
  output logic       set
);

  logic b_eff;
  logic sum;

  // Adder datapath and result select.
  always_comb begin
    b_eff = b ^ op[2];
    sum   = a ^ b_eff ^ cin;
    co    = (a & b_eff) | (a & cin) | (b_eff & cin);
    set   = sum;
    unique case (op[1:0])
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = sum;
      default: r = less;
    endcase
  end

endmodule

// File: rtl/alu_bitserial_seq.sv
// Bit-serial sequencer: drives one alu1b slice LSB first over WIDTH cycles,
// feeding carry back through a register, then publishes result and flags.
//
//   state | meaning
//   IDLE  | waiting for start; operands latched on start
//   SHIFT | one bit per cycle through the slice
//   FIN   | result/flags valid, done pulsed
module alu_bitserial_seq
  import alu_bitserial_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_bitserial_seq_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic slice_r, slice_co, slice_set;

  alu1b u_slice (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .less (1'b0),
    .op   (op_q),
    .r    (slice_r),
    .co   (slice_co),
    .set  (slice_set)
  );

  // State register and datapath flops; reset clears everything, zero idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      op_q     <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      op_q     <= op_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  // Next-state and datapath updates. Outputs are committed on the last SHIFT
  // edge so they are already stable during the FIN cycle while done is high.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    op_d     = op_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          op_d    = bus.op;
          carry_d = bus.op[2];
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        res_sh_d = {slice_r, res_sh_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = slice_co;
        if (cnt_q == CNT_LAST) begin
          // Raw sign of a-b: no overflow correction, matching ALU16.
          result_d = (op_q[1:0] == 2'b11) ? {{(WIDTH-1){1'b0}}, slice_set} : res_sh_d;
          cout_d   = slice_co;
          ovf_d    = carry_q ^ slice_co;
          zero_d   = (result_d == '0);
          state_d  = FIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == FIN);
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
  assign bus.zero   = zero_q;

endmodule

// File: tb/tb_alu_bitserial_seq.sv
// Scoreboard bench for the bit-serial ALU sequencer.
module tb_alu_bitserial_seq;
  import alu_bitserial_seq_pkg::*;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic         zero;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   done_cnt = 0;
  exp_t sb_q[$];

  alu_bitserial_seq_if #(.WIDTH(W)) bus_if ();

  alu_bitserial_seq #(.WIDTH(W), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t       e;
    logic [W-1:0] bb;
    logic [W:0]   s;
    bb = op[2] ? ~b : b;
    s  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, op[2]};
    case (op[1:0])
      2'b00:   e.result = a & b;
      2'b01:   e.result = a | b;
      2'b10:   e.result = s[W-1:0];
      default: e.result = {{(W-1){1'b0}}, s[W-1]};
    endcase
    e.cout = s[W];
    e.ovf  = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
    e.zero = (e.result == '0);
    return e;
  endfunction

  // Monitor: every done pulse pops one expected entry and compares.
  always @(negedge clk) begin
    if (rst_n && bus_if.done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result", {16'h0, bus_if.result}, {16'h0, e.result});
        chk("cout", {31'h0, bus_if.cout}, {31'h0, e.cout});
        chk("ovf", {31'h0, bus_if.ovf}, {31'h0, e.ovf});
        chk("zero", {31'h0, bus_if.zero}, {31'h0, e.zero});
      end
    end
  end

  always @(posedge clk) begin
    if (bus_if.done) done_cnt++;
  end

  // Drive one op, count edges from the start-sampling edge until done is seen.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat;
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.op    = op;
    bus_if.a     = a;
    bus_if.b     = b;
    sb_q.push_back(model(op, a, b));
    @(posedge clk);
    lat = 1;
    #1;
    bus_if.start = 1'b0;
    chk("busy_after_start", {31'h0, bus_if.busy}, 32'd1);
    while (!bus_if.done && lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
    end
    chk("done_latency", lat, 32'd17);
    @(posedge clk);
    #1;
    chk("done_single_cycle", {31'h0, bus_if.done}, 32'd0);
  endtask

  initial begin
    int d0;
    rst_n = 1'b0;
    bus_if.start = 1'b0;
    bus_if.op = OP_AND;
    bus_if.a = '0;
    bus_if.b = '0;
    #12;
    chk("rst_busy", {31'h0, bus_if.busy}, 32'd0);
    chk("rst_done", {31'h0, bus_if.done}, 32'd0);
    chk("rst_result", {16'h0, bus_if.result}, 32'd0);
    chk("rst_zero", {31'h0, bus_if.zero}, 32'd1);
    chk("rst_cout", {31'h0, bus_if.cout}, 32'd0);
    chk("rst_ovf", {31'h0, bus_if.ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(OP_ADD, 16'h1234, 16'h0FFF);
    run_op(OP_SUB, 16'h0005, 16'h0007);
    run_op(OP_SLT, 16'h0005, 16'h0007);
    run_op(OP_ADD, 16'h7FFF, 16'h0001);
    run_op(OP_SUB, 16'h8000, 16'h8000);
    run_op(OP_AND, 16'hF0F0, 16'h3C3C);
    run_op(OP_OR,  16'hF0F0, 16'h3C3C);
    run_op(OP_SLT, 16'h8000, 16'h0001);
    run_op(OP_ADD, 16'hFFFF, 16'h0001);
    for (int i = 0; i < 8; i++) begin
      run_op(3'(i), 16'($urandom), 16'($urandom));
    end

    // Second start while busy must be ignored.
    d0 = done_cnt;
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.op = OP_ADD;
    bus_if.a = 16'h1111;
    bus_if.b = 16'h2222;
    sb_q.push_back(model(OP_ADD, 16'h1111, 16'h2222));
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (4) @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.a = 16'h0F0F;
    bus_if.b = 16'h0101;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (24) @(negedge clk);
    chk("busy_restart_done_pulses", done_cnt - d0, 32'd1);
    chk("busy_restart_queue_empty", sb_q.size(), 32'd0);

    // Reset mid-SUB: outputs clear immediately, no done follows.
    d0 = done_cnt;
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.op = OP_SUB;
    bus_if.a = 16'h4321;
    bus_if.b = 16'h0123;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (7) @(negedge clk);
    chk("busy_before_rst", {31'h0, bus_if.busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'h0, bus_if.busy}, 32'd0);
    chk("midrst_result", {16'h0, bus_if.result}, 32'd0);
    chk("midrst_zero", {31'h0, bus_if.zero}, 32'd1);
    chk("midrst_done", {31'h0, bus_if.done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst_no_done", done_cnt - d0, 32'd0);
    run_op(OP_ADD, 16'h0001, 16'h0001);

    repeat (3) @(negedge clk);
    chk("queue_drained", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
